// File: rtl/core_ram_pkg.sv
// Shared types and constants for the core RAM responder: FSM states,
// grant-source encoding and latency counter width.
package core_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_LAT    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic SRC_IF  = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/core_ram_ctrl_if.sv
// Request/response bus between the core's fetch and load/store ports,
// the RAM responder and its synchronous SRAM.
interface core_ram_ctrl_if #(
    parameter int unsigned SRAM_AW = 12
) ();

    logic               if_req;
    logic [31:0]        if_addr;
    logic               if_done;
    logic [31:0]        if_rdata;
    logic               if_err;

    logic               mem_req;
    logic               mem_we;
    logic [3:0]         mem_be;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic               mem_done;
    logic [31:0]        mem_rdata;
    logic               mem_err;

    logic               sram_cs;
    logic               sram_we;
    logic [3:0]         sram_be;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;

    // Core requesters plus the SRAM macro
    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output sram_rdata,
        input  if_done, if_rdata, if_err,
        input  mem_done, mem_rdata, mem_err,
        input  sram_cs, sram_we, sram_be, sram_addr, sram_wdata
    );

    // RAM responder
    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  sram_rdata,
        output if_done, if_rdata, if_err,
        output mem_done, mem_rdata, mem_err,
        output sram_cs, sram_we, sram_be, sram_addr, sram_wdata
    );

endinterface

// File: rtl/core_ram_arb.sv
// Two-way arbiter for fetch vs. load/store; when both request, the port
// that did not win last time gets the grant.
module core_ram_arb
    import core_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  logic       mem_req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (if_req && mem_req) begin
                gnt[(last_q == SRC_MEM) ? SRC_IF : SRC_MEM] = 1'b1;
            end else if (mem_req) begin
                gnt[SRC_MEM] = 1'b1;
            end else if (if_req) begin
                gnt[SRC_IF] = 1'b1;
            end
        end
        last_d = (gnt != 2'b00) ? gnt[SRC_MEM] : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SRC_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/core_ram_ctrl.sv
// Single-port SRAM responder serving fetch and load/store requests with
// alternating arbitration, configurable read wait states and a done pulse.
module core_ram_ctrl
    import core_ram_pkg::*;
#(
    parameter int unsigned SRAM_AW     = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    core_ram_ctrl_if.slave bus,
    output logic           busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               src_q, src_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic               if_done_q, if_done_d;
    logic               if_err_q, if_err_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic               mem_done_q, mem_done_d;
    logic               mem_err_q, mem_err_d;
    logic [31:0]        mem_rdata_q, mem_rdata_d;
    logic               sram_cs_q, sram_cs_d;
    logic               sram_we_q, sram_we_d;
    logic [3:0]         sram_be_q, sram_be_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]        sram_wdata_q, sram_wdata_d;

    logic [1:0]         gnt;
    logic               sel_mem;
    logic               sel_we;
    logic               sel_err;
    logic [31:0]        sel_addr;
    logic               finish;
    logic [31:0]        rd_word;

    core_ram_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_req  (bus.if_req),
        .mem_req (bus.mem_req),
        .en      (state_q == ST_IDLE),
        .gnt     (gnt)
    );

    // Sub-word stores use byte enables, so only loads/fetches check alignment
    always_comb begin
        sel_mem  = gnt[SRC_MEM];
        sel_addr = sel_mem ? bus.mem_addr : bus.if_addr;
        sel_we   = sel_mem & bus.mem_we;
        sel_err  = ((sel_addr >> (SRAM_AW + 2)) != 32'd0) ||
                   (!sel_we && (sel_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        src_d        = src_q;
        we_d         = we_q;
        err_d        = err_q;
        sram_cs_d    = sram_cs_q;
        sram_we_d    = sram_we_q;
        sram_be_d    = sram_be_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_done_d    = 1'b0;
        if_err_d     = 1'b0;
        if_rdata_d   = '0;
        mem_done_d   = 1'b0;
        mem_err_d    = 1'b0;
        mem_rdata_d  = '0;
        finish       = 1'b0;
        rd_word      = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    state_d      = ST_ACCESS;
                    src_d        = sel_mem;
                    we_d         = sel_we;
                    err_d        = sel_err;
                    sram_cs_d    = !sel_err;
                    sram_we_d    = sel_we && !sel_err;
                    sram_be_d    = (sel_we && !sel_err) ? bus.mem_be : 4'b0000;
                    sram_addr_d  = sel_addr[SRAM_AW+1:2];
                    sram_wdata_d = sel_mem ? bus.mem_wdata : '0;
                end
            end
            ST_ACCESS: begin
                sram_cs_d = 1'b0;
                sram_we_d = 1'b0;
                sram_be_d = 4'b0000;
                // An erroring grant spends this slot with cs held low and
                // goes straight to DONE, giving the two-cycle error latency.
                if (err_q) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end else begin
                    state_d = ST_LAT;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            ST_LAT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            rd_word     = (err_q || we_q) ? 32'd0 : bus.sram_rdata;
            if_done_d   = (src_q == SRC_IF);
            mem_done_d  = (src_q == SRC_MEM);
            if_err_d    = err_q && (src_q == SRC_IF);
            mem_err_d   = err_q && (src_q == SRC_MEM);
            if_rdata_d  = (src_q == SRC_IF)  ? rd_word : 32'd0;
            mem_rdata_d = (src_q == SRC_MEM) ? rd_word : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            src_q        <= SRC_IF;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            if_done_q    <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            mem_done_q   <= 1'b0;
            mem_err_q    <= 1'b0;
            mem_rdata_q  <= '0;
            sram_cs_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_be_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            src_q        <= src_d;
            we_q         <= we_d;
            err_q        <= err_d;
            if_done_q    <= if_done_d;
            if_err_q     <= if_err_d;
            if_rdata_q   <= if_rdata_d;
            mem_done_q   <= mem_done_d;
            mem_err_q    <= mem_err_d;
            mem_rdata_q  <= mem_rdata_d;
            sram_cs_q    <= sram_cs_d;
            sram_we_q    <= sram_we_d;
            sram_be_q    <= sram_be_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign bus.if_done    = if_done_q;
    assign bus.if_err     = if_err_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_done   = mem_done_q;
    assign bus.mem_err    = mem_err_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.sram_cs    = sram_cs_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_be    = sram_be_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;

endmodule

// File: doc/core_ram_ctrl.md
Name: core_ram_ctrl

Overview:
- Single-port RAM responder at the far end of the core's memory request interfaces.
- Serves instruction-fetch reads (IF port) and load/store accesses (MEM port) against one synchronous SRAM.
- Arbitrates between the two ports, sequences the SRAM access with configurable wait states, and returns a one-cycle done pulse with read data or an error flag.

Parameters:
SRAM_AW, 12, SRAM word-address width; capacity 2^SRAM_AW 32-bit words
WAIT_CYCLES, 0, extra SRAM read-latency cycles (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held high until if_done
if_addr  in  32  fetch byte address
if_done  out  1  one-cycle completion pulse for fetch
if_rdata  out  32  fetched word; valid while if_done=1
if_err  out  1  fetch error; qualified by if_done
mem_req  in  1  load/store request; held high until mem_done
mem_we  in  1  1=store, 0=load
mem_be  in  4  byte enables for store; ignored for load
mem_addr  in  32  byte address
mem_wdata  in  32  store data
mem_done  out  1  one-cycle completion pulse
mem_rdata  out  32  load word; valid while mem_done=1
mem_err  out  1  error; qualified by mem_done
busy  out  1  FSM not IDLE
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write strobe
sram_be  out  4  SRAM byte enables
sram_addr  out  SRAM_AW  SRAM word address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data; valid WAIT_CYCLES+1 cycles after the cs cycle

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0: done, err, rdata, sram_*. last_grant=IF.
- FSM states:
  - IDLE: sample requests.
  - ACCESS: 1 cycle; sram_cs=1, plus sram_we/be for stores.
  - LAT: WAIT_CYCLES+1 cycles; cs=0; sram_rdata captured on the edge leaving the last LAT cycle.
  - DONE: 1 cycle; done pulse; then IDLE.
- Arbitration, in IDLE only:
  - If only one port requests, grant it.
  - If both request, grant MEM unless last_grant==MEM, in which case grant IF (alternating).
  - last_grant updates on each grant.
- Address, we, be and wdata are latched at grant. Requester changes after grant are ignored.
- Latency, request high in IDLE at cycle 0: ACCESS in cycle 1, LAT in cycles 2..2+WAIT_CYCLES, done in cycle 3+WAIT_CYCLES.
- Back-to-back: the cycle after DONE is IDLE. A request still high in that cycle is a new transaction, so a requester must drop req on the edge where it samples done.
- Word address = addr[SRAM_AW+1:2].
- Error, checked at grant; erroring access skips ACCESS/LAT (no SRAM cycle), goes to DONE next cycle (done in cycle 2), err=1, rdata=0:
  - IF: if_addr[1:0]!=0, or addr[31:SRAM_AW+2]!=0.
  - MEM load: addr[1:0]!=0 or out of range. Store: out of range only; sub-word stores use mem_be with addr[1:0] ignored.
- Store: sram_we=1, sram_be=mem_be in ACCESS. be=4'b0000 still runs the cycle with no byte written. mem_rdata=0 on store done.
- Only the granted port's done pulses. The other port's done/err stay 0 and its rdata holds 0.
- Requester drops req mid-transaction: transaction still completes and done still pulses. Stores must not be aborted.
- Reset asserted mid-transaction: immediate IDLE, sram_cs=0, no done. Any partial SRAM write is the SRAM's concern.

Decomposition:
- Package core_ram_pkg: FSM state enum (IDLE/ACCESS/LAT/DONE), grant source constants (SRC_IF, SRC_MEM), WAIT_CYCLES counter width constant (4).
- Sub-module core_ram_arb: 2-way alternating-priority arbiter. Inputs: two reqs, an enable (state==IDLE). Outputs: one-hot grant. Holds last_grant register.

Test Plan:
- Single fetch, WAIT_CYCLES=0, SRAM word 0x10=0xDEADBEEF: if_req with if_addr=0x40 at cycle 0 -> sram_cs in cycle 1 with sram_addr=0x10, if_done=1 and if_rdata=0xDEADBEEF in cycle 3, if_err=0.
- Store then load: mem_we=1, be=4'b0011, addr=0x8, wdata=0x12345678 over existing 0xFFFFFFFF -> load addr 0x8 returns 0xFFFF5678. WAIT_CYCLES=2 places mem_done in cycle 5.
- Contention: if_req and mem_req high together from IDLE, held continuously -> grant sequence MEM, IF, MEM, IF (reset last_grant=IF). Never two dones in one cycle.
- Errors: if_addr=0x42 -> if_done in cycle 2, if_err=1, no sram_cs. mem load addr=0x4000 with SRAM_AW=12 -> mem_err=1, no sram_cs.
- Mid-transaction: mem_req dropped during LAT -> mem_done still pulses once. rst_n low during LAT -> sram_cs=0, busy=0 immediately, no done afterwards.
- Back-to-back: if_req held high through done -> second fetch starts (ACCESS) two cycles after DONE, with a fresh address latched in the IDLE cycle.
